// File: rtl/boe_tx.sv
// Byte-oriented frame transmitter: buffers up to MAX_LEN bytes, replays them with a length tag
// on the first byte, then holds an idle gap sized to the frame before accepting the next one.
module boe_tx #(
    parameter int MAX_LEN   = 6,
    parameter int GAP_EXTRA = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic [2:0] data_num,
    output logic [7:0] data_out,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {LOAD, SEND, GAP} state_t;

    state_t     r_state;
    logic [2:0] r_len;
    logic [2:0] r_idx;
    logic [3:0] r_gap;
    logic [7:0] r_buf [MAX_LEN];
    logic       r_in_ready;
    logic [2:0] r_data_num;
    logic [7:0] r_data_out;
    logic       r_busy;
    logic [7:0] r_frame_cnt;

    logic w_accept;
    logic w_close;

    assign w_accept = (r_state == LOAD) && in_valid;
    assign w_close  = w_accept && (in_last || (r_len == 3'(MAX_LEN - 1)));

    assign in_ready  = r_in_ready;
    assign data_num  = r_data_num;
    assign data_out  = r_data_out;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= LOAD;
            r_len       <= '0;
            r_idx       <= '0;
            r_gap       <= '0;
            r_in_ready  <= 1'b1;
            r_data_num  <= '0;
            r_data_out  <= '0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
            // NOTE: the buffer is reset as well, so a discarded frame never leaks into the next one.
            for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_buf[r_len] <= in_data;
                        r_len        <= r_len + 3'd1;
                        if (w_close) begin
                            r_state    <= SEND;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_data_num <= r_len + 3'd1;
                            // A one-byte frame closes before buf[0] is written, so forward the input.
                            r_data_out <= (r_len == 3'd0) ? in_data : r_buf[0];
                            r_idx      <= 3'd1;
                        end
                    end
                end
                SEND: begin
                    r_data_num <= '0;
                    if (r_idx == r_len) begin
                        r_state    <= GAP;
                        r_data_out <= '0;
                        r_gap      <= 4'(r_len) + 4'(GAP_EXTRA) - 4'd1;
                    end else begin
                        r_data_out <= r_buf[r_idx];
                        r_idx      <= r_idx + 3'd1;
                    end
                end
                GAP: begin
                    if (r_gap == 4'd0) begin
                        r_state     <= LOAD;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                        r_len       <= '0;
                        r_idx       <= '0;
                        for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= '0;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_boe_tx.sv
// Directed bench for boe_tx: each loaded frame pushes its expected per-cycle outputs into a
// scoreboard queue, which is then drained cycle by cycle against the DUT.
module tb_boe_tx;

    localparam int MAX_LEN   = 6;
    localparam int GAP_EXTRA = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [2:0] data_num;
    logic [7:0] data_out;
    logic       busy;
    logic [7:0] frame_cnt;

    typedef struct {
        logic [2:0] num;
        logic [7:0] dout;
        logic       bsy;
        logic       rdy;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] stim [8];
    logic [7:0] exp_cnt;
    int         total = 0;
    int         bad   = 0;

    boe_tx #(.MAX_LEN(MAX_LEN), .GAP_EXTRA(GAP_EXTRA)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .data_num(data_num), .data_out(data_out), .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives stim[0..n-1] one byte per cycle and queues the expected SEND, GAP and first LOAD cycles.
    task automatic load_frame(input int n, input bit use_last);
        exp_t e;
        check("in_ready_load", in_ready, 1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = stim[i];
            in_last  = use_last && (i == n - 1);
            e = '{num: (i == 0) ? 3'(n) : 3'd0, dout: stim[i], bsy: 1'b1, rdy: 1'b0, cnt: exp_cnt};
            sb.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < n + GAP_EXTRA; i++) begin
            e = '{num: 3'd0, dout: 8'h00, bsy: 1'b1, rdy: 1'b0, cnt: exp_cnt};
            sb.push_back(e);
        end
        exp_cnt = exp_cnt + 8'd1;
        e = '{num: 3'd0, dout: 8'h00, bsy: 1'b0, rdy: 1'b1, cnt: exp_cnt};
        sb.push_back(e);
    endtask

    // Compares one queued entry per cycle; stops on the first LOAD cycle after the gap.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check("data_num", data_num, e.num);
            check("data_out", data_out, e.dout);
            check("busy", busy, e.bsy);
            check("in_ready", in_ready, e.rdy);
            check("frame_cnt", frame_cnt, e.cnt);
            if (sb.size() > 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_cnt = 8'd0;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        exp_cnt  = 8'd0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_data_num", data_num, 0);
        check("rst_data_out", data_out, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset on the second SEND cycle of a 4-byte frame.
        stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
        load_frame(4, 1'b1);
        sb.delete();
        check("send1_num", data_num, 4);
        check("send1_out", data_out, 1);
        @(posedge clk); #1;
        check("send2_out", data_out, 2);
        rst = 1'b0;
        #1;
        check("midrst_num", data_num, 0);
        check("midrst_out", data_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cnt", frame_cnt, 0);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_cnt = 8'd0;
        check("postrst_ready", in_ready, 1);
        stim = '{8'd9, 8'd8, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        load_frame(3, 1'b1);
        drain();

        // 3,7,1 with in_last on the third byte.
        stim = '{8'd3, 8'd7, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        load_frame(3, 1'b1);
        drain();

        // Six bytes with no in_last: closes on the MAX_LEN-th byte.
        stim = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd0, 8'd0};
        load_frame(6, 1'b0);
        drain();

        // Single byte 0xFF.
        stim = '{8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        load_frame(1, 1'b1);
        drain();

        // in_valid held high through SEND/GAP: the held byte opens the next frame.
        stim = '{8'h11, 8'h22, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        load_frame(2, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        drain();
        stim = '{8'hAA, 8'hBB, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        load_frame(2, 1'b1);
        drain();

        // 256 one-byte frames from a cleared counter.
        pulse_reset();
        check("wrap_start_cnt", frame_cnt, 0);
        for (int i = 0; i < 256; i++) begin
            stim[0] = 8'(i);
            load_frame(1, 1'b1);
            drain();
        end
        check("wrap_cnt", frame_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
